// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter in front of a UART TX FIFO; grant one edge after req, then one byte per cycle.
// Backpressure: tx_full stalls the owner indefinitely; the link is held until the message completes or req drops.
module uart_tx_arbiter #(
    parameter int NumReq   = 4,
    parameter int DataBits = 8,
    parameter int LenWidth = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NumReq-1:0]            req,
    input  logic [NumReq*LenWidth-1:0]   req_len,
    input  logic [NumReq*DataBits-1:0]   req_data,
    input  logic                         tx_full,
    output logic                         write_uart,
    output logic [DataBits-1:0]          w_data,
    output logic [NumReq-1:0]            grant,
    output logic [NumReq-1:0]            byte_ack,
    output logic [NumReq-1:0]            msg_done,
    output logic                         busy
);

    localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state;
    logic [PtrW-1:0]     ptr;
    logic [PtrW-1:0]     gidx;
    logic [LenWidth-1:0] remaining;

    logic                win_found;
    logic [PtrW-1:0]     win_idx;
    logic                in_send;
    logic                req_g;
    logic                accept;
    logic                done_hit;

    // Round-robin search starting just after the last winner.
    always_comb begin : arb
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 1; k <= NumReq; k++) begin
            cand = (int'(ptr) + k) % NumReq;
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = PtrW'(cand);
            end
        end
    end

    assign in_send  = (state == SEND);
    assign req_g    = req[gidx];
    assign accept   = in_send && req_g && (remaining != '0) && !tx_full;
    // Zero-length messages complete in their first SEND cycle without a write.
    assign done_hit = (accept && (remaining == LenWidth'(1)))
                    || (in_send && req_g && (remaining == '0));

    assign write_uart = accept;
    assign w_data     = accept ? req_data[int'(gidx)*DataBits +: DataBits] : '0;
    assign byte_ack   = accept ? grant : '0;
    assign msg_done   = done_hit ? grant : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= '0;
            gidx      <= '0;
            remaining <= '0;
            ptr       <= PtrW'(NumReq - 1);
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant          <= '0;
                        grant[win_idx] <= 1'b1;
                        gidx           <= win_idx;
                        ptr            <= win_idx;
                        remaining      <= req_len[int'(win_idx)*LenWidth +: LenWidth];
                        state          <= SEND;
                        busy           <= 1'b1;
                    end
                end
                SEND: begin
                    // Abort, zero-length completion and last-byte completion all release the link.
                    if (!req_g || done_hit) begin
                        state     <= IDLE;
                        grant     <= '0;
                        remaining <= '0;
                        busy      <= 1'b0;
                    end else if (accept) begin
                        remaining <= remaining - LenWidth'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
